// File: rtl/lc3b_types.sv
// lc3b_types: shared cache-line widths and flattened-bus slice helpers.
package lc3b_types;
    localparam int LINE_ADDR_WIDTH = 12;
    localparam int LINE_DATA_WIDTH = 128;
    localparam int LINE_SEL_WIDTH = 16;
    localparam int DEFAULT_CNT_WIDTH = 16;
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction
endpackage

// File: rtl/wb_rr_interconnect_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester after last wins.
module rr_pick #(
    parameter int N = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          valid
);
    always_comb begin
        winner = '0;
        valid = |req;
        // descending offset so the nearest index after last is assigned last and wins
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) winner = IW'((int'(last) + k) % N);
        end
    end
endmodule

// File: rtl/wb_rr_interconnect.sv
// wb_rr_interconnect: round-robin arbitration of NUM_MASTERS wishbone masters onto one L2 port,
// grant held until ack/retry/abort, with saturating per-master grant counters.
module wb_rr_interconnect
    import lc3b_types::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH = LINE_ADDR_WIDTH,
    parameter int DATA_WIDTH = LINE_DATA_WIDTH,
    parameter int SEL_WIDTH = LINE_SEL_WIDTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_cyc,
    input  logic [NUM_MASTERS-1:0]            m_stb,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_m,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_rty,
    output logic [DATA_WIDTH-1:0]             m_dat_s,
    output logic                              s_cyc,
    output logic                              s_stb,
    output logic                              s_we,
    output logic [ADDR_WIDTH-1:0]             s_adr,
    output logic [SEL_WIDTH-1:0]              s_sel,
    output logic [DATA_WIDTH-1:0]             s_dat_m,
    input  logic                              s_ack,
    input  logic                              s_rty,
    input  logic [DATA_WIDTH-1:0]             s_dat_s,
    input  logic [NUM_MASTERS-1:0]            grant_clear,
    output logic [NUM_MASTERS*CNT_WIDTH-1:0]  grant_cnt,
    output logic [$clog2(NUM_MASTERS)-1:0]    grant_id,
    output logic                              busy
);
    localparam int IW = $clog2(NUM_MASTERS);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] last, winner;
    logic [NUM_MASTERS-1:0] req;
    logic valid, grant, done;
    logic [CNT_WIDTH-1:0] cnt [NUM_MASTERS];
    assign req = m_cyc | m_stb;
    assign busy = state == BUSY;
    assign grant = state == IDLE && valid;
    // a granted master dropping its request is an abort and releases the bus
    assign done = busy && (s_ack || s_rty || !req[grant_id]);
    assign m_dat_s = s_dat_s;
    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req(req),
        .last(last),
        .winner(winner),
        .valid(valid)
    );
    always_comb begin
        state_nxt = grant ? BUSY : done ? IDLE : state;
        s_cyc = busy && m_cyc[grant_id];
        s_stb = busy && m_stb[grant_id];
        s_we = busy && m_we[grant_id];
        s_adr = busy ? m_adr[slice_lsb(int'(grant_id), ADDR_WIDTH) +: ADDR_WIDTH] : '0;
        s_sel = busy ? m_sel[slice_lsb(int'(grant_id), SEL_WIDTH) +: SEL_WIDTH] : '0;
        s_dat_m = busy ? m_dat_m[slice_lsb(int'(grant_id), DATA_WIDTH) +: DATA_WIDTH] : '0;
        m_ack = busy ? NUM_MASTERS'(s_ack) << grant_id : '0;
        m_rty = busy ? NUM_MASTERS'(s_rty) << grant_id : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last <= IW'(NUM_MASTERS - 1);
            grant_id <= '0;
        end else begin
            state <= state_nxt;
            if (grant) grant_id <= winner;
            if (done) last <= grant_id;
        end
    end
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst || grant_clear[g]) cnt[g] <= '0;
            else if (grant && winner == IW'(g) && cnt[g] != '1) cnt[g] <= cnt[g] + 1'b1;
        end
        assign grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
    end
endmodule

// File: tb/tb_wb_rr_interconnect.sv
// tb_wb_rr_interconnect: directed checks of a 2-master default instance and a 4-master
// instance with 4-bit counters (so saturation is reachable in a short run).
module tb_wb_rr_interconnect;
    logic clk = 0, rst = 0;
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;

    logic [1:0] a_cyc, a_stb, a_we, a_ack, a_rty, a_clr;
    logic [23:0] a_adr;
    logic [31:0] a_sel, a_cnt;
    logic [255:0] a_datm;
    logic [127:0] a_dats, a_sdatm, a_sdats;
    logic a_scyc, a_sstb, a_swe, a_sack, a_srty, a_busy;
    logic [11:0] a_sadr;
    logic [15:0] a_ssel;
    logic [0:0] a_gid;

    logic [3:0] b_cyc, b_stb, b_we, b_ack, b_rty, b_clr;
    logic [47:0] b_adr;
    logic [63:0] b_sel;
    logic [511:0] b_datm;
    logic [127:0] b_dats, b_sdatm, b_sdats;
    logic b_scyc, b_sstb, b_swe, b_sack, b_srty, b_busy;
    logic [11:0] b_sadr;
    logic [15:0] b_ssel, b_cnt;
    logic [1:0] b_gid;

    wb_rr_interconnect dut_a (
        .clk(clk), .rst(rst), .m_cyc(a_cyc), .m_stb(a_stb), .m_we(a_we), .m_adr(a_adr),
        .m_sel(a_sel), .m_dat_m(a_datm), .m_ack(a_ack), .m_rty(a_rty), .m_dat_s(a_dats),
        .s_cyc(a_scyc), .s_stb(a_sstb), .s_we(a_swe), .s_adr(a_sadr), .s_sel(a_ssel),
        .s_dat_m(a_sdatm), .s_ack(a_sack), .s_rty(a_srty), .s_dat_s(a_sdats),
        .grant_clear(a_clr), .grant_cnt(a_cnt), .grant_id(a_gid), .busy(a_busy)
    );

    wb_rr_interconnect #(.NUM_MASTERS(4), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .m_cyc(b_cyc), .m_stb(b_stb), .m_we(b_we), .m_adr(b_adr),
        .m_sel(b_sel), .m_dat_m(b_datm), .m_ack(b_ack), .m_rty(b_rty), .m_dat_s(b_dats),
        .s_cyc(b_scyc), .s_stb(b_sstb), .s_we(b_swe), .s_adr(b_sadr), .s_sel(b_ssel),
        .s_dat_m(b_sdatm), .s_ack(b_sack), .s_rty(b_srty), .s_dat_s(b_sdats),
        .grant_clear(b_clr), .grant_cnt(b_cnt), .grant_id(b_gid), .busy(b_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        a_cyc = 0; a_stb = 0; a_we = 0; a_adr = 0; a_sel = 0; a_datm = 0;
        a_sack = 0; a_srty = 0; a_sdats = 0; a_clr = 0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_adr = 0; b_sel = 0; b_datm = 0;
        b_sack = 0; b_srty = 0; b_sdats = 0; b_clr = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        a_cyc = 2'b11; a_stb = 2'b11;
        b_cyc = 4'b1111; b_stb = 4'b1111;
        rst = 1;
        tick();
        tick();
        vectors++; if (a_scyc !== 1'b0) begin miscompares++; $display("FAIL reset_s_cyc got %b exp 0", a_scyc); end
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", a_busy); end
        vectors++; if (a_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_cnt_a got %h exp 0", a_cnt); end
        vectors++; if (b_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_cnt_b got %h exp 0", b_cnt); end
        vectors++; if (a_gid !== 1'b0) begin miscompares++; $display("FAIL reset_gid got %h exp 0", a_gid); end
        rst = 0;
        tick();
        vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("FAIL reset_first_busy got %b exp 1", a_busy); end
        vectors++; if (a_gid !== 1'b0) begin miscompares++; $display("FAIL reset_first_gid got %h exp 0", a_gid); end
        vectors++; if (a_scyc !== 1'b1) begin miscompares++; $display("FAIL reset_first_s_cyc got %b exp 1", a_scyc); end
        vectors++; if (b_gid !== 2'd0) begin miscompares++; $display("FAIL reset_first_gid_b got %h exp 0", b_gid); end
    endtask

    task automatic test_single;
        logic [127:0] line;
        line = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        do_reset();
        a_adr = {12'h0A3, 12'h555};
        a_cyc = 2'b10; a_stb = 2'b10;
        tick();
        vectors++; if (a_gid !== 1'b1) begin miscompares++; $display("FAIL single_gid got %h exp 1", a_gid); end
        vectors++; if (a_sadr !== 12'h0A3) begin miscompares++; $display("FAIL single_s_adr got %h exp 0a3", a_sadr); end
        vectors++; if (a_scyc !== 1'b1) begin miscompares++; $display("FAIL single_s_cyc got %b exp 1", a_scyc); end
        tick();
        tick();
        vectors++; if (a_ack !== 2'b00) begin miscompares++; $display("FAIL single_early_ack got %b exp 00", a_ack); end
        a_sack = 1; a_sdats = line;
        #1;
        vectors++; if (a_ack !== 2'b10) begin miscompares++; $display("FAIL single_ack got %b exp 10", a_ack); end
        vectors++; if (a_dats !== line) begin miscompares++; $display("FAIL single_dat got %h exp %h", a_dats, line); end
        tick();
        a_sack = 0; a_cyc = 0; a_stb = 0;
        #1;
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL single_idle got %b exp 0", a_busy); end
        vectors++; if (a_cnt !== {16'd1, 16'd0}) begin miscompares++; $display("FAIL single_cnt got %h exp 00010000", a_cnt); end
    endtask

    task automatic test_contention;
        int exp;
        do_reset();
        a_cyc = 2'b11; a_stb = 2'b11;
        for (int t = 0; t < 6; t++) begin
            exp = t % 2;
            tick();
            vectors++; if (a_busy !== 1'b1 || a_gid !== 1'(exp)) begin miscompares++; $display("FAIL contention_gid[%0d] got %h exp %0d", t, a_gid, exp); end
            a_sack = 1;
            #1;
            vectors++; if (a_ack !== 2'(1 << exp)) begin miscompares++; $display("FAIL contention_ack[%0d] got %b exp %b", t, a_ack, 2'(1 << exp)); end
            tick();
            a_sack = 0;
            #1;
            vectors++; if (a_scyc !== 1'b0) begin miscompares++; $display("FAIL contention_dead[%0d] got %b exp 0", t, a_scyc); end
        end
        vectors++; if (a_cnt !== {16'd3, 16'd3}) begin miscompares++; $display("FAIL contention_cnt got %h exp 00030003", a_cnt); end
        a_cyc = 0; a_stb = 0;
        tick();
    endtask

    task automatic test_retry_abort;
        do_reset();
        a_cyc = 2'b01; a_stb = 2'b01;
        tick();
        a_srty = 1;
        #1;
        vectors++; if (a_rty !== 2'b01) begin miscompares++; $display("FAIL retry_rty got %b exp 01", a_rty); end
        vectors++; if (a_ack !== 2'b00) begin miscompares++; $display("FAIL retry_ack got %b exp 00", a_ack); end
        tick();
        a_srty = 0; a_cyc = 0; a_stb = 0;
        #1;
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL retry_idle got %b exp 0", a_busy); end
        a_adr = {12'h1B2, 12'h0C4};
        a_cyc = 2'b10; a_stb = 2'b10;
        tick();
        vectors++; if (a_gid !== 1'b1) begin miscompares++; $display("FAIL abort_gid got %h exp 1", a_gid); end
        a_cyc = 2'b11; a_stb = 2'b11;
        #1;
        vectors++; if (a_sadr !== 12'h1B2) begin miscompares++; $display("FAIL abort_no_leak got %h exp 1b2", a_sadr); end
        tick();
        a_cyc = 2'b01; a_stb = 2'b01;
        #1;
        vectors++; if (a_ack !== 2'b00) begin miscompares++; $display("FAIL abort_ack got %b exp 00", a_ack); end
        tick();
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle got %b exp 0", a_busy); end
        tick();
        vectors++; if (a_busy !== 1'b1 || a_gid !== 1'b0) begin miscompares++; $display("FAIL abort_next_gid got %h busy %b exp 0 busy 1", a_gid, a_busy); end
        a_sack = 1;
        tick();
        a_sack = 0; a_cyc = 0; a_stb = 0;
        tick();
    endtask

    task automatic test_four;
        do_reset();
        b_cyc = 4'b0010; b_stb = 4'b0010;
        tick();
        vectors++; if (b_gid !== 2'd1) begin miscompares++; $display("FAIL four_first_gid got %h exp 1", b_gid); end
        b_sack = 1;
        tick();
        b_sack = 0; b_cyc = 4'b1010; b_stb = 4'b1010;
        tick();
        vectors++; if (b_gid !== 2'd3) begin miscompares++; $display("FAIL four_gid3 got %h exp 3", b_gid); end
        b_sack = 1;
        #1;
        vectors++; if (b_ack !== 4'b1000) begin miscompares++; $display("FAIL four_ack3 got %b exp 1000", b_ack); end
        tick();
        b_sack = 0; b_cyc = 4'b0010; b_stb = 4'b0010;
        #1;
        vectors++; if (b_busy !== 1'b0) begin miscompares++; $display("FAIL four_dead got %b exp 0", b_busy); end
        tick();
        vectors++; if (b_gid !== 2'd1) begin miscompares++; $display("FAIL four_gid1 got %h exp 1", b_gid); end
        b_sack = 1;
        #1;
        vectors++; if (b_ack !== 4'b0010) begin miscompares++; $display("FAIL four_ack1 got %b exp 0010", b_ack); end
        tick();
        b_sack = 0; b_cyc = 0; b_stb = 0;
        tick();
    endtask

    task automatic test_counter;
        do_reset();
        b_cyc = 4'b0001; b_stb = 4'b0001;
        for (int n = 1; n <= 17; n++) begin
            tick();
            b_sack = 1;
            tick();
            b_sack = 0;
            if (n == 15) begin
                vectors++; if (b_cnt[3:0] !== 4'hF) begin miscompares++; $display("FAIL counter_full got %h exp f", b_cnt[3:0]); end
            end
        end
        vectors++; if (b_cnt !== 16'h000F) begin miscompares++; $display("FAIL counter_sat got %h exp 000f", b_cnt); end
        b_clr = 4'b0001;
        tick();
        vectors++; if (b_busy !== 1'b1 || b_cnt[3:0] !== 4'h0) begin miscompares++; $display("FAIL counter_clear got %h busy %b exp 0 busy 1", b_cnt[3:0], b_busy); end
        b_clr = 0; b_sack = 1;
        tick();
        b_sack = 0;
        tick();
        vectors++; if (b_cnt[3:0] !== 4'h1) begin miscompares++; $display("FAIL counter_after_clear got %h exp 1", b_cnt[3:0]); end
        b_sack = 1;
        tick();
        b_sack = 0; b_cyc = 0; b_stb = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_retry_abort();
        test_four();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_rr_interconnect.md
# wb_rr_interconnect

Parametrised successor to the two-cache L2 interconnect. Arbitrates NUM_MASTERS wishbone masters (I-cache, D-cache, prefetcher, DMA, …) onto the single L2 wishbone slave port using registered round-robin arbitration, holding each grant until its transaction ends. Adds per-master grant counters for the performance-counter MMIO path.

## Interface
Parameters:
- NUM_MASTERS, 2, number of master ports (≥2)
- ADDR_WIDTH, 12, line address width
- DATA_WIDTH, 128, line data width
- SEL_WIDTH, 16, byte-select width (DATA_WIDTH/8)
- CNT_WIDTH, 16, grant-counter width

Ports (master i occupies slice i of each flattened bus, index 0 at LSB):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- m_cyc, m_stb, m_we  in  NUM_MASTERS each  master cycle/strobe/write
- m_adr  in  NUM_MASTERS*ADDR_WIDTH  master addresses
- m_sel  in  NUM_MASTERS*SEL_WIDTH  master byte selects
- m_dat_m  in  NUM_MASTERS*DATA_WIDTH  master write data
- m_ack, m_rty  out  NUM_MASTERS each  ack/retry, routed to granted master only
- m_dat_s  out  DATA_WIDTH  read data, broadcast to all masters
- s_cyc, s_stb, s_we  out  1 each  to L2
- s_adr  out  ADDR_WIDTH; s_sel  out  SEL_WIDTH; s_dat_m  out  DATA_WIDTH
- s_ack, s_rty  in  1 each; s_dat_s  in  DATA_WIDTH  from L2
- grant_clear  in  NUM_MASTERS  per-master counter clear
- grant_cnt  out  NUM_MASTERS*CNT_WIDTH  per-master grant counts
- grant_id  out  $clog2(NUM_MASTERS)  current/last granted master
- busy  out  1  high while in BUSY

## Operation
- Request of master i: req[i] = m_cyc[i] | m_stb[i].
- State IDLE: s_cyc/s_stb/s_we = 0, s_adr/s_sel/s_dat_m = 0, all m_ack/m_rty = 0. If any req: winner = first requesting index scanning last+1, last+2, … modulo NUM_MASTERS; register grant_id = winner, go BUSY.
- State BUSY: s_* outputs = granted master's m_* signals (combinational mux). m_ack[grant_id] = s_ack, m_rty[grant_id] = s_rty; other masters see 0.
- BUSY exit: s_ack or s_rty → IDLE, last = grant_id. Granted master's req drops without ack (abort) → IDLE, last = grant_id, L2 response in that cycle still forwarded.
- Non-granted requests wait; their signals never reach L2.
- m_dat_s = s_dat_s always.
- Counters: grant_cnt[i] increments on each IDLE→BUSY transition granting i; saturates at all-ones; grant_clear[i] forces 0 and has priority over same-cycle increment.

## Timing
- Reset (rst high at edge): state IDLE, last = NUM_MASTERS-1 (master 0 wins first contended arbitration), grant_id = 0, busy = 0, all grant_cnt = 0; rst mid-transaction abandons it with no m_ack issued.
- Arbitration latency: req seen in IDLE at edge n → s_cyc/s_stb high in cycle n+1.
- s_ack in cycle k → m_ack to granted master in cycle k (zero latency); state IDLE in k+1; next grant earliest k+2 on L2. One dead cycle between back-to-back transactions is required.
- Same-cycle requests from all masters with persistent demand are served in strict rotation; no master waits more than NUM_MASTERS-1 transactions.
- s_ack while IDLE ignored (not forwarded).

## Structure
- CNT_WIDTH default and the flattened-bus slice helpers go in lc3b_types alongside existing cache widths.
- State enum (IDLE, BUSY) local to module.
- One sub-module: rr_pick (combinational round-robin priority picker: req vector + last index → winner index, valid).

## Test plan
- Reset: assert rst 2 cycles with all m_cyc high → s_cyc=0, busy=0, grant_cnt all 0; release → master 0 granted next cycle.
- Single master: NUM_MASTERS=2, master 1 read adr 0x0A3, L2 acks after 3 cycles with data 0xDEAD…BEEF → m_ack[1] pulse that cycle, m_ack[0]=0, m_dat_s matches, grant_cnt[1]=1.
- Contention: both masters request continuously for 6 transactions → grant order 0,1,0,1,0,1; one idle L2 cycle between each; counts 3/3.
- NUM_MASTERS=4, masters 1 and 3 requesting, last=1 → grant 3, then 1; masters 0,2 never see ack.
- Retry/abort: s_rty on master 0 transaction → m_rty[0] only, IDLE next cycle; master 1 drops m_cyc mid-BUSY → IDLE, no ack, next requester granted.
- Counter: force grant_cnt[0] to 0xFFFF via 65535 grants → stays 0xFFFF on next grant; grant_clear[0] coincident with grant → 0.
